// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - segment code table and types shared by the hex scan display
package hex_disp_pkg;

    // Segments a..g, index 0 is segment a; a 0 bit lights the segment.
    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    // Codes for hex digits 0..F, indexed directly by the nibble value.
    localparam seg_t [0:15] SEG_CODES = {
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

endpackage

// File: rtl/hex_seg_decode.sv
// rtl/hex_seg_decode.sv - combinational nibble to seven-segment decoder with blanking
module hex_seg_decode
    import hex_disp_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [0:6] seg
);

    // Blank wins over the nibble so suppression and blinking share one path.
    always_comb begin
        seg = blank ? SEG_BLANK : SEG_CODES[nibble];
    end

endmodule

// File: rtl/hex_scan_display.sv
// rtl/hex_scan_display.sv - multiplexed hex display driver; optional blink via HEX_SCAN_BLINK_EN
module hex_scan_display
    import hex_disp_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    load,
    input  logic                    lzs_en,
`ifdef HEX_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [0:6]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_start
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int PTR_W = $clog2(NUM_DIGITS);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 2 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("NUM_DIGITS must be 2..8");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("SCAN_DIV must be at least 2");
    end
    if (BLINK_FRAMES < 1) begin : g_bad_blink
        $error("BLINK_FRAMES must be at least 1");
    end

    logic [PRE_W-1:0]        prescaler;
    logic [PTR_W-1:0]        pointer;
    logic                    running;
    logic                    tick;
    logic                    frame_wrap;
    logic [4*NUM_DIGITS-1:0] shadow;
    logic [4*NUM_DIGITS-1:0] active;
    logic                    pending;
    logic [NUM_DIGITS-1:0]   upper_zero;
    logic [3:0]              cur_nibble;
    logic                    digit_blank;
    logic [0:6]              dec_seg;

    // The first tick after reset opens the digit-0 slot instead of advancing,
    // so it counts as a frame boundary like every later wrap to 0.
    assign tick       = (prescaler == PRE_LAST);
    assign frame_wrap = tick && ((pointer == PTR_LAST) || !running);

    // Prescaler and digit pointer, both wrapping explicitly at their last value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            pointer   <= '0;
            running   <= 1'b0;
        end else begin
            prescaler <= tick ? '0 : prescaler + 1'b1;
            if (tick) begin
                running <= 1'b1;
                pointer <= frame_wrap ? '0 : pointer + 1'b1;
            end
        end
    end

    // Double buffer: a load coinciding with the wrap still transfers the old shadow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (frame_wrap && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (frame_wrap) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef HEX_SCAN_BLINK_EN
    localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

    logic [FC_W-1:0]       frame_cnt;
    logic                  blink_phase;
    logic [NUM_DIGITS-1:0] blink_live;

    // Frame counter toggles the blink phase; the mask is captured once per slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            blink_live  <= '0;
        end else begin
            if (tick) begin
                blink_live <= blink_mask;
            end
            if (frame_wrap) begin
                if (frame_cnt == FC_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end
`endif

    // upper_zero[i]: every nibble from i up to the top digit is zero.
    always_comb begin
        upper_zero = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            upper_zero[i] = ((active >> (4 * i)) == '0);
        end
    end

    // Select the current digit's nibble and decide whether it is blanked.
    always_comb begin
        cur_nibble  = active[{pointer, 2'b00} +: 4];
        digit_blank = lzs_en && (pointer != '0) && upper_zero[pointer];
`ifdef HEX_SCAN_BLINK_EN
        if (blink_phase && blink_live[pointer]) begin
            digit_blank = 1'b1;
        end
`endif
    end

    hex_seg_decode u_decode (
        .nibble (cur_nibble),
        .blank  (digit_blank),
        .seg    (dec_seg)
    );

    // Output registers: one dark cycle after each tick, then the lit digit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg         <= SEG_BLANK;
            dig_sel     <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_wrap;
            if (tick) begin
                seg     <= SEG_BLANK;
                dig_sel <= '1;
            end else if (running) begin
                seg     <= dec_seg;
                dig_sel <= ~(NUM_DIGITS'(1) << pointer);
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// tb/tb_hex_scan_display.sv - directed self-checking bench for hex_scan_display
module tb_hex_scan_display;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   value;
    logic          load;
    logic          lzs_en;
`ifdef HEX_SCAN_BLINK_EN
    logic [3:0]    blink_mask;
`endif
    logic [0:6]    seg;
    logic [3:0]    dig_sel;
    logic          frame_start;

    int checks = 0;
    int errors = 0;
    logic [0:6] frame_seg [4];

    hex_scan_display #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .load        (load),
        .lzs_en      (lzs_en),
`ifdef HEX_SCAN_BLINK_EN
        .blink_mask  (blink_mask),
`endif
        .seg         (seg),
        .dig_sel     (dig_sel),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_frame_start();
        int n;
        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frame_start !== 1'b1) begin
            errors++;
            $display("FAIL frame_start_timeout: frame_start=%b required 1", frame_start);
        end
    endtask

    task automatic read_frame();
        for (int d = 0; d < 4; d++) frame_seg[d] = 'x;
        repeat (15) begin
            @(negedge clk);
            for (int d = 0; d < 4; d++) begin
                if (dig_sel[d] === 1'b0) frame_seg[d] = seg;
            end
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; load = 1'b0; value = '0; lzs_en = 1'b0;
`ifdef HEX_SCAN_BLINK_EN
        blink_mask = '0;
`endif
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (dig_sel !== 4'b1110) begin
            errors++;
            $display("FAIL pre_reset_lit: dig_sel=%b required 1110", dig_sel);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (seg !== 7'h7F || dig_sel !== 4'b1111 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: seg=%h dig_sel=%b fs=%b required 7f 1111 0", seg, dig_sel, frame_start);
        end
    endtask

    task automatic test_first_frame();
        logic [3:0] exp_dig;
        logic [0:6] exp_seg;
        logic       exp_fs;
        int k;
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 36; n++) begin
            @(negedge clk);
            if (n < SD - 1) begin
                exp_dig = 4'hF; exp_seg = 7'h7F; exp_fs = 1'b0;
            end else begin
                k = n - (SD - 1);
                exp_fs = ((k % (SD * ND)) == 0);
                if ((k % SD) == 0) begin
                    exp_dig = 4'hF; exp_seg = 7'h7F;
                end else begin
                    exp_dig = ~(4'b0001 << ((k / SD) % ND));
                    exp_seg = 7'h01;
                end
            end
            checks++;
            if (dig_sel !== exp_dig || seg !== exp_seg || frame_start !== exp_fs) begin
                errors++;
                $display("FAIL first_frame n=%0d: dig_sel=%b seg=%h fs=%b required %b %h %b",
                         n, dig_sel, seg, frame_start, exp_dig, exp_seg, exp_fs);
            end
        end
    endtask

    task automatic test_load_tearing();
        logic [0:6] exp_f [4];
        wait_frame_start();
        repeat (8) @(negedge clk);
        do_load(16'h1234);
        checks++;
        if (dig_sel !== 4'b1011 || seg !== 7'h01) begin
            errors++;
            $display("FAIL tear_digit2: dig_sel=%b seg=%h required 1011 01", dig_sel, seg);
        end
        repeat (6) begin
            @(negedge clk);
            if (dig_sel !== 4'b1111) begin
                checks++;
                if (seg !== 7'h01) begin
                    errors++;
                    $display("FAIL tear_hold: dig_sel=%b seg=%h required 01", dig_sel, seg);
                end
            end
        end
        wait_frame_start();
        read_frame();
        exp_f = '{7'h4C, 7'h06, 7'h12, 7'h4F};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL tear_frame digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:6] exp_f [4];
        wait_frame_start();
        repeat (2) @(negedge clk);
        do_load(16'hA5F0);
        repeat (3) @(negedge clk);
        do_load(16'h00C3);
        wait_frame_start();
        read_frame();
        exp_f = '{7'h06, 7'h31, 7'h01, 7'h01};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL back_to_back digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
    endtask

    task automatic test_load_at_wrap();
        logic [0:6] exp_f [4];
        wait_frame_start();
        repeat (4) @(negedge clk);
        do_load(16'h0042);
        repeat (10) @(negedge clk);
        value = 16'h0007;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        checks++;
        if (frame_start !== 1'b1 || dut.pending !== 1'b1) begin
            errors++;
            $display("FAIL wrap_load: fs=%b pending=%b required 1 1", frame_start, dut.pending);
        end
        read_frame();
        exp_f = '{7'h12, 7'h4C, 7'h01, 7'h01};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL wrap_old digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
        wait_frame_start();
        checks++;
        if (dut.pending !== 1'b0) begin
            errors++;
            $display("FAIL wrap_pending_clear: pending=%b required 0", dut.pending);
        end
        read_frame();
        exp_f = '{7'h0F, 7'h01, 7'h01, 7'h01};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL wrap_new digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
    endtask

    task automatic test_lzs();
        logic [0:6] exp_f [4];
        lzs_en = 1'b1;
        wait_frame_start();
        do_load(16'h0000);
        wait_frame_start();
        read_frame();
        exp_f = '{7'h01, 7'h7F, 7'h7F, 7'h7F};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL lzs_zero digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
        wait_frame_start();
        do_load(16'h0100);
        wait_frame_start();
        read_frame();
        exp_f = '{7'h01, 7'h01, 7'h4F, 7'h7F};
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== exp_f[d]) begin
                errors++;
                $display("FAIL lzs_0100 digit%0d: seg=%h required %h", d, frame_seg[d], exp_f[d]);
            end
        end
    endtask

    task automatic test_reset_pending();
        lzs_en = 1'b0;
        wait_frame_start();
        do_load(16'hFFFF);
        reset = 1'b1;
        #1;
        checks++;
        if (dut.pending !== 1'b0 || seg !== 7'h7F || dig_sel !== 4'hF) begin
            errors++;
            $display("FAIL reset_mid: pending=%b seg=%h dig_sel=%b required 0 7f 1111", dut.pending, seg, dig_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_frame_start();
        read_frame();
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (frame_seg[d] !== 7'h01) begin
                errors++;
                $display("FAIL reset_lost_load digit%0d: seg=%h required 01", d, frame_seg[d]);
            end
        end
    endtask

`ifdef HEX_SCAN_BLINK_EN
    task automatic test_blink();
        int blanks;
        blanks = 0;
        lzs_en = 1'b0;
        blink_mask = 4'b0001;
        wait_frame_start();
        do_load(16'hFFFF);
        for (int f = 0; f < 4; f++) begin
            wait_frame_start();
            read_frame();
            for (int d = 1; d < 4; d++) begin
                checks++;
                if (frame_seg[d] !== 7'h38) begin
                    errors++;
                    $display("FAIL blink_steady f%0d digit%0d: seg=%h required 38", f, d, frame_seg[d]);
                end
            end
            checks++;
            if (frame_seg[0] !== 7'h38 && frame_seg[0] !== 7'h7F) begin
                errors++;
                $display("FAIL blink_digit0 f%0d: seg=%h required 38 or 7f", f, frame_seg[0]);
            end
            if (frame_seg[0] === 7'h7F) blanks++;
        end
        checks++;
        if (blanks != 2) begin
            errors++;
            $display("FAIL blink_duty: blank frames=%0d required 2 of 4", blanks);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_first_frame();
        test_load_tearing();
        test_back_to_back();
        test_load_at_wrap();
        test_lzs();
        test_reset_pending();
`ifdef HEX_SCAN_BLINK_EN
        test_blink();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
